// File: rtl/aes_keyexp_word_ctrl.sv
// Word-serial AES-128/192/256 key expansion: one schedule word per cycle, packed into round keys on a valid/ready stream.
// Optional round-key store enabled by defining RKEY_STORE_EN.
module aes_keyexp_word_ctrl #(
  parameter int NK       = 4,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [255:0]        key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic [31:0]         sbox_addr,
  input  logic [31:0]         sbox_data,
  output logic [127:0]        rk_data,
  output logic [RK_IDX_W-1:0] rk_round,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic                busy,
  output logic                done,
  input  logic [RK_IDX_W-1:0] rd_round,
  output logic [127:0]        rd_key
);

  localparam int         NR      = NK + 6;
  localparam int         NW      = 4 * (NR + 1);
  localparam logic [5:0] LAST_I  = 6'(NW - 1);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GEN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_keyexp_word_ctrl: NK must be 4, 6 or 8");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]           state;
  logic [5:0]           i;
  logic [2:0]           kmod;
  logic [7:0]           rcon;
  logic [NK-1:0][31:0]  win;   // win[0] = w[i-NK], win[NK-1] = w[i-1]
  logic [2:0][31:0]     acc;

  logic [31:0]  prev, t, w_new;
  logic [127:0] rk_next;
  logic         key_phase, rot_phase, sub_phase;
  logic         rk_load, stall, gen_en, accept;

  assign prev      = win[NK-1];
  assign key_phase = (i < 6'(NK));
  assign rot_phase = !key_phase && (kmod == 3'd0);
  assign sub_phase = (NK == 8) && !key_phase && (kmod == 3'd4);

  assign sbox_addr = rot_phase ? {prev[23:0], prev[31:24]} : prev;

  always_comb begin
    t = prev;
    if (rot_phase)      t = sbox_data ^ {rcon, 24'h0};
    else if (sub_phase) t = sbox_data;
  end

  // Key words pass through win[0] unchanged; after NK shifts the window is back in key order.
  assign w_new   = key_phase ? win[0] : (win[0] ^ t);
  assign rk_next = {acc[0], acc[1], acc[2], w_new};

  assign rk_load   = (i[1:0] == 2'd3);
  assign stall     = rk_load && rk_valid && !rk_ready;
  assign gen_en    = (state == S_GEN) && !stall;
  assign key_ready = (state == S_IDLE);
  assign accept    = key_valid && key_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      i        <= '0;
      kmod     <= '0;
      rcon     <= 8'h01;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= S_GEN;
          i     <= '0;
          kmod  <= '0;
          rcon  <= 8'h01;
          done  <= 1'b0;
          busy  <= 1'b1;
        end
        S_GEN: if (gen_en) begin
          i    <= i + 6'd1;
          kmod <= (kmod == NK_LAST) ? 3'd0 : kmod + 3'd1;
          if (rot_phase)   rcon  <= xtime(rcon);
          if (i == LAST_I) state <= S_FLUSH;
        end
        S_FLUSH: if (rk_valid && rk_ready) begin
          state <= S_IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (gen_en && rk_load) begin
        rk_valid <= 1'b1;
        rk_data  <= rk_next;
        rk_round <= RK_IDX_W'(i[5:2]);
      end else if (rk_ready) begin
        rk_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
      acc <= '0;
    end else if (accept) begin
      for (int j = 0; j < NK; j++) win[j] <= key_in[255-32*j -: 32];
    end else if (gen_en) begin
      for (int j = 0; j < NK-1; j++) win[j] <= win[j+1];
      win[NK-1] <= w_new;
      if (!rk_load) acc[i[1:0]] <= w_new;
    end
  end

`ifdef RKEY_STORE_EN
  logic [127:0] rk_mem [0:NR];

  always_ff @(posedge clk) begin
    if (gen_en && rk_load) rk_mem[i[5:2]] <= rk_next;
  end

  assign rd_key = (rd_round <= RK_IDX_W'(NR)) ? rk_mem[rd_round] : '0;
`else
  logic unused_rd;
  assign unused_rd = ^rd_round;
  assign rd_key    = '0;
`endif

  logic unused_key;
  assign unused_key = ^key_in;

endmodule
